sprite_line_render: RTL and testbench
=====================================

Name: sprite_line_render

Overview:
- Receiving end of the sprite image load sequence.
- Captures one line of pixel data per sprite channel from sprite memory while the matching load-enable bit is high.
- Commits all captured lines together on the load-done pulse.
- Scans the captured lines out against the VGA horizontal counter, producing one prioritised sprite pixel per clock for the colour mixer.
- Sits between the sprite memory/loader and the VGA pixel mux.

Parameters:
- NSPR, 5, number of sprite channels; must match the loader's load_en width.
- WIDTH, 16, sprite width in pixels.
- BPP, 2, bits per pixel (palette index); index 0 is transparent.
- HW, 10, width of the horizontal counter and sprite X positions.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset.
- linebegin  in  1  one-cycle pulse at the start of each scan line.
- load_en  in  NSPR  one-hot; bit i high means rom_data is channel i's line data this cycle.
- rom_data  in  WIDTH*BPP  sprite line data; pixel 0 is in the MS BPP bits.
- img_load_done  in  1  one-cycle pulse; all channels have been loaded.
- sprite_en  in  NSPR  per-channel display enable.
- sprite_x  in  NSPR*HW  packed X start positions; channel i is at bits [i*HW +: HW].
- hcount  in  HW  current pixel column.
- pix_valid  out  1  an opaque sprite pixel is present.
- pix_idx  out  BPP  palette index of the winning pixel.
- pix_sprite  out  3  channel number of the winning pixel.

Behaviour:
- Reset:
  - rst is synchronous, active-high; clock is clk.
  - On reset: pix_valid=0, pix_idx=0, pix_sprite=0.
  - All shadow and active line registers are cleared to 0.
  - All channel FSMs go to IDLE and all pixel counters to 0.
  - A reset mid-draw blanks the output on the next cycle.
- Capture:
  - On a cycle with load_en[i]=1, shadow[i] <= rom_data.
  - If load_en is not one-hot, every set bit captures the same data; no error flag is raised.
- Commit:
  - On img_load_done, active[i] <= shadow[i] for every i, and every channel goes to ARMED.
  - The commit uses shadow contents from before that cycle's write. A load_en write in the same cycle lands in shadow only.
- Per-channel FSM states:
  - IDLE: no output.
  - ARMED, on hcount==x_i with sprite_en[i]=1: go to DRAW with cnt_i=0.
  - DRAW: cnt_i increments each cycle. At cnt_i==WIDTH-1, go to DONE.
  - DONE: no output; wait.
- Line start:
  - linebegin forces every channel to IDLE, abandoning any draw in progress (sprites running past the line end are truncated).
  - If linebegin and img_load_done occur in the same cycle, img_load_done wins and channels go to ARMED.
- Disable:
  - sprite_en[i]=0 suppresses channel i's pixel in any state.
  - Clearing sprite_en[i] during DRAW does not stop the counter.
- Pixel timing:
  - The channel pixel is active[i] bits for index cnt_i. The candidate is opaque when sprite_en[i]=1 and the pixel is nonzero.
  - The hit cycle (hcount==x_i while ARMED) already presents pixel 0 combinationally, using cnt_i=0.
  - Output latency is one cycle: pixel k of a sprite at X appears on the outputs in the cycle after hcount==X+k.
- Priority:
  - The lowest-numbered opaque channel wins.
  - If no channel is opaque: pix_valid=0, pix_idx=0, pix_sprite=0.
- Arithmetic:
  - No X wrap-around. A sprite whose x exceeds the last active column never triggers and stays ARMED until linebegin.
- Re-arm:
  - A channel in DONE does not redraw on the same line unless a new img_load_done arrives.
  - A second img_load_done during DRAW restarts the channel in ARMED with the new data.

Test Plan:
- Reset, then load channel 0 with 0xE400_0000, pulse img_load_done, sprite_x0=100, sprite_en=1 -> pix_valid=1 at cycles after hcount 100,101,102 with idx 3,2,1; idx 0 at hcount 103 gives pix_valid=0; nothing after hcount 115.
- Channels 0 and 2 both at x=50, both all-3 data -> pix_sprite=0 for 16 pixels. Then clear ch0 data to all-0 -> pix_sprite=2, idx 3.
- Sprite at x=630 with an 800-cycle line, linebegin at hcount 0 -> pixels drawn for hcount 630..645; on the next line without img_load_done, no output.
- Pulse linebegin at hcount 105 while drawing from x=100 -> output blank from the following cycle.
- Same-cycle load_en[1] and img_load_done -> active[1] holds the previous shadow value; the next commit shows the new data.
- Same-cycle linebegin and img_load_done -> channels ARMED and drawing at their x. Assert rst mid-draw -> pix_valid=0 next cycle, and no draw until reload.

Source files
------------

// File: rtl/sprite_line_render.sv
// sprite_line_render
// Receiving end of the sprite image load sequence. Each sprite channel owns a
// shadow line register, filled from sprite memory while its load-enable bit is
// high, and an active line register that is drawn on screen. On the load-done
// pulse every shadow line is committed to its active line and every channel is
// armed. Armed channels start drawing when the VGA horizontal counter reaches
// their X position. The lowest-numbered opaque pixel wins and is registered
// towards the colour mixer.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous active-high reset
//   linebegin      one-cycle pulse at the start of each scan line
//   load_en        per-channel capture strobe for rom_data (normally one-hot)
//   rom_data       one sprite line, pixel 0 in the most significant BPP bits
//   img_load_done  one-cycle pulse: commit shadow lines and arm all channels
//   sprite_en      per-channel display enable
//   sprite_x       packed X start positions, channel i at [i*HW +: HW]
//   hcount         current pixel column
//   pix_valid      an opaque sprite pixel is present
//   pix_idx        palette index of the winning pixel
//   pix_sprite     channel number of the winning pixel
module sprite_line_render #(
    parameter int NSPR  = 5,
    parameter int WIDTH = 16,
    parameter int BPP   = 2,
    parameter int HW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  linebegin,
    input  logic [NSPR-1:0]       load_en,
    input  logic [WIDTH*BPP-1:0]  rom_data,
    input  logic                  img_load_done,
    input  logic [NSPR-1:0]       sprite_en,
    input  logic [NSPR*HW-1:0]    sprite_x,
    input  logic [HW-1:0]         hcount,
    output logic                  pix_valid,
    output logic [BPP-1:0]        pix_idx,
    output logic [2:0]            pix_sprite
);

    localparam int LW = WIDTH * BPP;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } chan_state_t;

    chan_state_t     state_q [NSPR];
    chan_state_t     state_d [NSPR];
    logic [CW-1:0]   cnt_q   [NSPR];
    logic [CW-1:0]   cnt_d   [NSPR];
    logic [LW-1:0]   shadow_q[NSPR];
    logic [LW-1:0]   active_q[NSPR];

    logic [NSPR-1:0] hit;
    logic [NSPR-1:0] drawing;
    logic [NSPR-1:0] opaque;
    logic [CW-1:0]   pix_k   [NSPR];
    logic [LW-1:0]   line_sh [NSPR];
    logic [BPP-1:0]  cand_idx[NSPR];

    logic            win_valid;
    logic [BPP-1:0]  win_idx;
    logic [2:0]      win_sprite;

    // Line storage. The commit copies the shadow contents as they were before
    // this edge, so a capture in the same cycle only reaches the shadow line.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSPR; i++) begin
            if (rst) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end else begin
                if (img_load_done) begin
                    active_q[i] <= shadow_q[i];
                end
                if (load_en[i]) begin
                    shadow_q[i] <= rom_data;
                end
            end
        end
    end

    // Channel state and pixel counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSPR; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-channel next state. The hit cycle itself shows pixel 0, so the
    // counter enters DRAW already pointing at pixel 1 and the last pixel is
    // shown in the cycle where it reads WIDTH-1. A commit beats linebegin.
    always_comb begin
        for (int i = 0; i < NSPR; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hit[i]     = (state_q[i] == ARMED) && sprite_en[i] &&
                         (hcount == sprite_x[i*HW +: HW]);
            if (img_load_done) begin
                state_d[i] = ARMED;
                cnt_d[i]   = '0;
            end else if (linebegin) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ARMED: begin
                        if (hit[i]) begin
                            state_d[i] = DRAW;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                    DRAW: begin
                        if (cnt_q[i] == CW'(WIDTH - 1)) begin
                            state_d[i] = DONE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = state_q[i];
                    end
                endcase
            end
        end
    end

    // Candidate pixel per channel. Shifting left by the pixel number brings
    // that pixel into the top BPP bits. A linebegin blanks every candidate so
    // a truncated sprite disappears from the next output cycle onward.
    always_comb begin
        for (int i = 0; i < NSPR; i++) begin
            drawing[i]  = hit[i] || (state_q[i] == DRAW);
            pix_k[i]    = (state_q[i] == DRAW) ? cnt_q[i] : '0;
            line_sh[i]  = active_q[i] << (int'(pix_k[i]) * BPP);
            cand_idx[i] = line_sh[i][LW-1 -: BPP];
            opaque[i]   = drawing[i] && sprite_en[i] && !linebegin &&
                          (cand_idx[i] != '0);
        end
    end

    // Priority select: scanning from the highest channel down lets the
    // lowest-numbered opaque channel overwrite the rest.
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        win_sprite = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_valid  = 1'b1;
                win_idx    = cand_idx[i];
                win_sprite = 3'(i);
            end
        end
    end

    // Output register: one cycle of latency towards the colour mixer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid  <= 1'b0;
            pix_idx    <= '0;
            pix_sprite <= '0;
        end else begin
            pix_valid  <= win_valid;
            pix_idx    <= win_idx;
            pix_sprite <= win_sprite;
        end
    end

endmodule

// File: tb/tb_sprite_line_render.sv
// tb_sprite_line_render
// Self-checking bench for sprite_line_render. A behavioural model tracks, per
// channel, whether it is armed and the cycle in which it started drawing; the
// expected pixel is the sprite's pixel at position (cycles since start), read
// arithmetically from the committed line. Directed scenarios add fixed-value
// checks, then a randomized phase runs short lines against the model.
module tb_sprite_line_render;

    logic        clk;
    logic        rst;
    logic        linebegin;
    logic [4:0]  load_en;
    logic [31:0] rom_data;
    logic        img_load_done;
    logic [4:0]  sprite_en;
    logic [49:0] sprite_x;
    logic [9:0]  hcount;
    logic        pix_valid;
    logic [1:0]  pix_idx;
    logic [2:0]  pix_sprite;

    int total = 0;
    int bad   = 0;
    int h     = 0;
    int cyc   = 0;

    logic [31:0] m_shadow[5];
    logic [31:0] m_active[5];
    bit          m_armed[5];
    bit          m_drawing[5];
    int          m_start[5];

    sprite_line_render #(
        .NSPR(5), .WIDTH(16), .BPP(2), .HW(10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .linebegin     (linebegin),
        .load_en       (load_en),
        .rom_data      (rom_data),
        .img_load_done (img_load_done),
        .sprite_en     (sprite_en),
        .sprite_x      (sprite_x),
        .hcount        (hcount),
        .pix_valid     (pix_valid),
        .pix_idx       (pix_idx),
        .pix_sprite    (pix_sprite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (hcount %0d)", tag, obs, exp, hcount);
        end
    endtask

    function automatic logic [9:0] xOf(input int i);
        return sprite_x[i*10 +: 10];
    endfunction

    // One clock: predict the registered output from the inputs now applied,
    // advance the model, clock the DUT and compare.
    task automatic tick();
        logic [31:0] oldSh[5];
        int          pos[5];
        bit          ev;
        int          eIdx, eSpr, px;
        hcount = h[9:0];
        ev = 0; eIdx = 0; eSpr = 0;
        for (int i = 0; i < 5; i++) begin
            pos[i] = -1;
            if (m_drawing[i]) pos[i] = cyc - m_start[i];
            else if (m_armed[i] && sprite_en[i] && hcount == xOf(i)) pos[i] = 0;
            if (!rst && !ev && pos[i] >= 0 && sprite_en[i] && !linebegin) begin
                px = int'((m_active[i] >> (2 * (15 - pos[i]))) & 32'd3);
                if (px != 0) begin
                    ev = 1; eIdx = px; eSpr = i;
                end
            end
        end
        for (int i = 0; i < 5; i++) oldSh[i] = m_shadow[i];
        for (int i = 0; i < 5; i++) begin
            if (rst) begin
                m_shadow[i] = 0; m_active[i] = 0;
                m_armed[i] = 0; m_drawing[i] = 0;
            end else begin
                if (load_en[i]) m_shadow[i] = rom_data;
                if (img_load_done) begin
                    m_active[i] = oldSh[i];
                    m_armed[i] = 1; m_drawing[i] = 0;
                end else if (linebegin) begin
                    m_armed[i] = 0; m_drawing[i] = 0;
                end else if (m_drawing[i]) begin
                    if (pos[i] >= 15) m_drawing[i] = 0;
                end else if (pos[i] == 0) begin
                    m_armed[i] = 0; m_drawing[i] = 1; m_start[i] = cyc;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        checkOutput("pix_valid", 32'(pix_valid), 32'(ev));
        checkOutput("pix_idx", 32'(pix_idx), 32'(eIdx));
        checkOutput("pix_sprite", 32'(pix_sprite), 32'(eSpr));
        h++;
    endtask

    task automatic applyStimulus(input bit lb, input logic [4:0] le,
                                 input logic [31:0] data, input bit done);
        linebegin     = lb;
        load_en       = le;
        rom_data      = data;
        img_load_done = done;
        tick();
        linebegin     = 0;
        load_en       = 0;
        img_load_done = 0;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 5'b0, $urandom, 0);
    endtask

    task automatic newLine();
        h = 0;
        applyStimulus(1, 5'b0, $urandom, 0);
    endtask

    task automatic runUntil(input int last);
        while (h <= last) idleCycle();
    endtask

    task automatic setX(input int i, input int x);
        sprite_x[i*10 +: 10] = 10'(x);
    endtask

    initial begin
        rst = 1; linebegin = 0; load_en = 0; rom_data = 0; img_load_done = 0;
        sprite_en = 0; sprite_x = 0; hcount = 0;
        for (int i = 0; i < 5; i++) begin
            m_shadow[i] = 0; m_active[i] = 0; m_armed[i] = 0; m_drawing[i] = 0; m_start[i] = 0;
        end

        // Reset state
        idleCycle();
        idleCycle();
        checkOutput("reset_valid", 32'(pix_valid), 0);
        rst = 0;

        // Single sprite, pixels 3,2,1,0 from X=100
        setX(0, 100); sprite_en = 5'b00001;
        newLine();
        applyStimulus(0, 5'b00001, 32'hE400_0000, 0);
        applyStimulus(0, 5'b0, $urandom, 1);
        runUntil(100); checkOutput("tp1_idx100", 32'(pix_idx), 3);
        checkOutput("tp1_val100", 32'(pix_valid), 1);
        runUntil(101); checkOutput("tp1_idx101", 32'(pix_idx), 2);
        runUntil(102); checkOutput("tp1_idx102", 32'(pix_idx), 1);
        runUntil(103); checkOutput("tp1_val103", 32'(pix_valid), 0);
        runUntil(130);

        // Priority: channels 0 and 2 overlap at X=50
        setX(0, 50); setX(2, 50); sprite_en = 5'b00101;
        newLine();
        applyStimulus(0, 5'b00001, 32'hFFFF_FFFF, 0);
        applyStimulus(0, 5'b00100, 32'hFFFF_FFFF, 0);
        applyStimulus(0, 5'b0, $urandom, 1);
        runUntil(50); checkOutput("tp2_spr50", 32'(pix_sprite), 0);
        runUntil(65); checkOutput("tp2_val65", 32'(pix_valid), 1);
        runUntil(66); checkOutput("tp2_val66", 32'(pix_valid), 0);
        runUntil(90);
        newLine();
        applyStimulus(0, 5'b00001, 32'h0, 0);
        applyStimulus(0, 5'b0, $urandom, 1);
        runUntil(55); checkOutput("tp2_spr55", 32'(pix_sprite), 2);
        checkOutput("tp2_idx55", 32'(pix_idx), 3);
        runUntil(90);

        // Right-edge sprite on an 800-cycle line, then no redraw
        setX(0, 630); sprite_en = 5'b00001;
        newLine();
        applyStimulus(0, 5'b00001, 32'hFFFF_FFFF, 0);
        applyStimulus(0, 5'b0, $urandom, 1);
        runUntil(630); checkOutput("tp3_val630", 32'(pix_valid), 1);
        runUntil(645); checkOutput("tp3_val645", 32'(pix_valid), 1);
        runUntil(646); checkOutput("tp3_val646", 32'(pix_valid), 0);
        runUntil(799);
        newLine();
        runUntil(630); checkOutput("tp3_nodraw", 32'(pix_valid), 0);
        runUntil(799);

        // linebegin mid-draw truncates the sprite
        setX(0, 100);
        newLine();
        applyStimulus(0, 5'b0, $urandom, 1);
        runUntil(104); checkOutput("tp4_val104", 32'(pix_valid), 1);
        applyStimulus(1, 5'b0, $urandom, 0);
        checkOutput("tp4_val105", 32'(pix_valid), 0);
        runUntil(120); checkOutput("tp4_val120", 32'(pix_valid), 0);

        // Same-cycle capture and commit
        setX(1, 200); sprite_en = 5'b00010;
        newLine();
        applyStimulus(0, 5'b00010, 32'h4000_0000, 0);
        applyStimulus(0, 5'b0, $urandom, 1);
        applyStimulus(0, 5'b00010, 32'h8000_0000, 1);
        runUntil(200); checkOutput("tp5_old", 32'(pix_idx), 1);
        checkOutput("tp5_spr", 32'(pix_sprite), 1);
        runUntil(220);
        newLine();
        applyStimulus(0, 5'b0, $urandom, 1);
        runUntil(200); checkOutput("tp5_new", 32'(pix_idx), 2);
        runUntil(220);

        // Same-cycle linebegin and commit, then reset mid-draw
        setX(0, 20); sprite_en = 5'b00001;
        h = 0;
        applyStimulus(1, 5'b0, $urandom, 1);
        runUntil(20); checkOutput("tp6_val20", 32'(pix_valid), 1);
        runUntil(22);
        rst = 1;
        idleCycle();
        checkOutput("tp6_rstblank", 32'(pix_valid), 0);
        rst = 0;
        runUntil(60); checkOutput("tp6_nodraw", 32'(pix_valid), 0);
        newLine();
        applyStimulus(0, 5'b0, $urandom, 1);
        runUntil(60);

        // Randomized lines against the model
        for (int line = 0; line < 12; line++) begin
            for (int i = 0; i < 5; i++) setX(i, int'($urandom_range(0, 259)));
            sprite_en = 5'($urandom);
            newLine();
            while (h < 200) begin
                logic [4:0]  le;
                logic [31:0] d;
                bit          dn, lb;
                le = 5'b0;
                if ($urandom_range(0, 7) == 0) le = 5'(1 << $urandom_range(0, 4));
                else if ($urandom_range(0, 49) == 0) le = 5'($urandom);
                d  = $urandom & $urandom;
                dn = ($urandom_range(0, 39) == 0);
                lb = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 99) == 0) sprite_en = 5'($urandom);
                if (lb) begin
                    linebegin = 1; load_en = le; rom_data = d; img_load_done = dn;
                    tick();
                    linebegin = 0; load_en = 0; img_load_done = 0;
                end else begin
                    applyStimulus(0, le, d, dn);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
